// File: rtl/sys_bus_pkg.sv
// rtl/sys_bus_pkg.sv - shared types and helpers for the system bus arbiter
//
// Contents:
//   arb_state_e  arbiter FSM states (IDLE, OWN, RELEASE)
//   MAX_MASTERS  largest number of masters the arbiter is built for
//   cnt_width()  width of the ownership counter for a given watchdog limit
package sys_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int MAX_MASTERS = 8;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so the
    // counter register never collapses to zero width.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req    in   N   candidate request vector (already masked by the caller)
//   start  in   W   index of the previous winner; search begins at start+1
//   valid  out  1   at least one candidate present
//   win    out  W   index of the first candidate found, wrapping past N-1 to 0
module rr_pick
    import sys_bus_pkg::*;
#(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         valid,
    output logic [W-1:0] win
);

    // The search never spans more slots than the arbiter is built for.
    localparam int LOOP_N = (N < MAX_MASTERS) ? N : MAX_MASTERS;

    logic [W-1:0] idx;

    // Walk the candidates from the farthest offset to the nearest one; the
    // last hit written is the nearest to start+1, which is the round-robin
    // winner. This avoids a separate "found" flag in the loop.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        idx   = '0;
        for (int off = LOOP_N; off >= 1; off--) begin
            idx = W'((int'(start) + off) % N);
            if (req[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin system bus arbiter with ownership watchdog
//
// Shares the single system bus among NUM_MASTERS masters. One master owns the
// bus at a time and keeps it until it drops its request or the watchdog fires.
//
// Ports:
//   clk          in   1            system clock, rising edge
//   rst          in   1            synchronous reset, active-high
//   req          in   NUM_MASTERS  per-master bus request, held for a transaction
//   grant        out  NUM_MASTERS  one-hot grant, registered
//   msel         out  MSEL_W       index of the granted master (bus mux select)
//   bus_busy     out  1            high while any grant is asserted
//   timeout_err  out  1            one-cycle pulse when the watchdog revokes a grant
module bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int TIMEOUT     = 256,
    localparam int MSEL_W      = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [MSEL_W-1:0]      msel,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    // Saturation value and the count at which the watchdog trips. The counter
    // is zero on the first owned cycle, so tripping at TIMEOUT-1 revokes the
    // grant after exactly TIMEOUT owned cycles.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_e             state, state_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [MSEL_W-1:0]      msel_d;
    logic [MSEL_W-1:0]      rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [NUM_MASTERS-1:0] penalty, penalty_d;
    logic                   timeout_err_d;

    logic [NUM_MASTERS-1:0] avail;
    logic                   pick_valid;
    logic [MSEL_W-1:0]      pick_win;
    logic                   owner_req;
    logic                   timeout_hit;

    // Masters that were cut off by the watchdog sit out until they drop req.
    assign avail = req & ~penalty;

    rr_pick #(
        .N (NUM_MASTERS),
        .W (MSEL_W)
    ) u_pick (
        .req   (avail),
        .start (rr_ptr),
        .valid (pick_valid),
        .win   (pick_win)
    );

    // msel always names the current owner while in OWN.
    assign owner_req   = req[msel];
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    assign bus_busy = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            msel        <= '0;
            rr_ptr      <= MSEL_W'(NUM_MASTERS - 1);
            cnt         <= '0;
            penalty     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            msel        <= msel_d;
            rr_ptr      <= rr_ptr_d;
            cnt         <= cnt_d;
            penalty     <= penalty_d;
            timeout_err <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state;
        grant_d       = grant;
        msel_d        = msel;
        rr_ptr_d      = rr_ptr;
        cnt_d         = cnt;
        timeout_err_d = 1'b0;
        // A penalty bit clears on any edge where that master is not requesting.
        penalty_d     = penalty & req;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = OWN;
                    grant_d           = '0;
                    grant_d[pick_win] = 1'b1;
                    msel_d            = pick_win;
                    rr_ptr_d          = pick_win;
                    cnt_d             = '0;
                end
            end

            OWN: begin
                if (cnt != CNT_MAX) begin
                    cnt_d = cnt + 1'b1;
                end
                // A voluntary release wins over a watchdog hit in the same
                // cycle: no error and no penalty in that case.
                if (!owner_req) begin
                    state_d = RELEASE;
                    grant_d = '0;
                end else if (timeout_hit) begin
                    state_d         = RELEASE;
                    grant_d         = '0;
                    timeout_err_d   = 1'b1;
                    penalty_d[msel] = 1'b1;
                end
            end

            RELEASE: begin
                // One turnaround cycle with the bus idle before arbitrating.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking testbench for bus_arbiter
module tb_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant;
    logic [0:0]   msel;
    logic         bus_busy;
    logic         timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, how many cycles it has held it,
    // whether the turnaround cycle is pending, and which masters are barred.
    int           m_owner = -1;
    int           m_held  = 0;
    int           m_last  = N - 1;
    int           m_msel  = 0;
    int           m_gap   = 0;
    bit [N-1:0]   m_pen   = '0;
    bit           m_terr  = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS (N),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .msel        (msel),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    task automatic model_step();
        bit [N-1:0] avail;
        bit [N-1:0] newpen;
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = N - 1; m_msel = 0;
            m_gap = 0; m_pen = '0; m_terr = 1'b0;
            return;
        end
        m_terr = 1'b0;
        avail  = req & ~m_pen;
        newpen = m_pen & req;
        if (m_owner >= 0) begin
            m_held++;
            if (!req[m_owner]) begin
                m_owner = -1;
                m_gap   = 1;
            end else if (TO != 0 && m_held == TO) begin
                newpen[m_owner] = 1'b1;
                m_terr  = 1'b1;
                m_owner = -1;
                m_gap   = 1;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else if (avail != 0) begin
            for (int k = 1; k <= N; k++) begin
                if (avail[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    break;
                end
            end
            m_last = m_owner;
            m_msel = m_owner;
            m_held = 0;
        end
        m_pen = newpen;
    endtask

    function automatic logic [N+2:0] exp_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, 1'(m_msel), (m_owner >= 0), m_terr};
    endfunction

    function automatic logic [N+2:0] obs_vec();
        return {grant, msel, bus_busy, timeout_err};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if ({grant, msel, bus_busy, timeout_err} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b required 00000", i, {grant, msel, bus_busy, timeout_err});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_handover();
        logic [N-1:0] want [3];
        want = '{2'b00, 2'b00, 2'b10};
        req = 2'b11;
        cycle();
        n_checks++;
        if ({grant, msel} !== 3'b010) begin
            n_fail++;
            $display("FAIL handover_first: got grant=%b msel=%b required grant=01 msel=0", grant, msel);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL handover_hold[%0d]: got %b required %b", i, obs_vec(), exp_vec());
            end
        end
        req = 2'b10;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (grant !== want[i] || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL handover_gap[%0d]: got grant=%b all=%b required grant=%b all=%b",
                         i, grant, obs_vec(), want[i], exp_vec());
            end
        end
        n_checks++;
        if (msel !== 1'b1) begin
            n_fail++;
            $display("FAIL handover_msel: got %b required 1", msel);
        end
        req = 2'b00;
        repeat (3) cycle();
    endtask

    task automatic test_round_robin();
        int who;
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            for (int w = 0; w < 6 && grant == 0; w++) begin
                cycle();
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rr_wait[%0d]: got %b required %b", t, obs_vec(), exp_vec());
                end
            end
            n_checks++;
            if (grant == 0) begin
                n_fail++;
                $display("FAIL rr_grant_timeout[%0d]: got grant=%b required a grant within 6 cycles", t, grant);
                who = 0;
            end else begin
                who = grant[1] ? 1 : 0;
            end
            n_checks++;
            if (who !== (t % 2)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got master %0d required master %0d", t, who, t % 2);
            end
            repeat (3) begin
                cycle();
                n_checks++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL rr_hold[%0d]: got %b required %b", t, obs_vec(), exp_vec());
                end
            end
            req[who] = 1'b0;
            cycle();
            req[who] = 1'b1;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_release[%0d]: got %b required %b", t, obs_vec(), exp_vec());
            end
        end
        req = 2'b00;
        repeat (3) cycle();
    endtask

    task automatic test_timeout();
        int hi = 0;
        int pulses = 0;
        req = 2'b01;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL timeout_run[%0d]: got %b required %b", i, obs_vec(), exp_vec());
            end
            if (grant[0]) hi++;
            if (timeout_err) pulses++;
        end
        n_checks++;
        if (hi != TO || pulses != 1) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d grant cycles %0d pulses required %0d and 1", hi, pulses, TO);
        end
        req = 2'b11;
        cycle();
        n_checks++;
        if (grant !== 2'b10 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL timeout_other: got grant=%b required 10", grant);
        end
        req = 2'b00;
        cycle();
        req = 2'b01;
        repeat (2) cycle();
        n_checks++;
        if (grant !== 2'b01 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL timeout_regrant: got grant=%b all=%b required grant=01 all=%b",
                     grant, obs_vec(), exp_vec());
        end
        req = 2'b00;
        repeat (3) cycle();
    endtask

    task automatic test_drop_at_timeout();
        req = 2'b01;
        for (int w = 0; w < 6 && grant == 0; w++) cycle();
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_grant: got grant=%b required 01", grant);
        end
        repeat (TO - 1) begin
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drop_hold: got %b required %b", obs_vec(), exp_vec());
            end
        end
        req = 2'b00;
        cycle();
        n_checks++;
        if (timeout_err !== 1'b0 || grant !== 2'b00 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL drop_edge: got terr=%b grant=%b required terr=0 grant=00", timeout_err, grant);
        end
        req = 2'b01;
        repeat (2) cycle();
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_regrant: got grant=%b required 01", grant);
        end
        req = 2'b00;
        repeat (3) cycle();
    endtask

    task automatic test_reset_mid_own();
        req = 2'b01;
        for (int w = 0; w < 6 && grant == 0; w++) cycle();
        repeat (2) cycle();
        rst = 1'b1;
        req = 2'b11;
        cycle();
        n_checks++;
        if (grant !== 2'b00 || timeout_err !== 1'b0 || bus_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_own: got grant=%b terr=%b busy=%b required 00 0 0", grant, timeout_err, bus_busy);
        end
        rst = 1'b0;
        cycle();
        n_checks++;
        if ({grant, msel} !== 3'b010 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rst_ptr: got grant=%b msel=%b required grant=01 msel=0", grant, msel);
        end
        req = 2'b00;
        repeat (3) cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(63) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) req[b] = ~req[b];
            end
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: req=%b got %b required %b", i, req, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_handover();
        test_round_robin();
        test_timeout();
        test_drop_at_timeout();
        test_reset_mid_own();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
